// File: rtl/hazard_lights.sv
// Wind-indicator hazard lights: free-running 32-bit divider and a 3-LED pattern FSM
// that advances on a divider-derived step enable (or every clock in simulation mode).
module hazard_lights #(
    parameter int DIV_BIT = 25,
    parameter bit USE_DIV = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  wind,
    output logic [2:0]  leds,
    output logic [31:0] divided_clocks,
    output logic        step
);

    typedef enum logic [2:0] {
        ST_OUTER = 3'b101,
        ST_MID   = 3'b010,
        ST_LEFT  = 3'b100,
        ST_RIGHT = 3'b001
    } state_t;

    // Low DIV_BIT+1 bits of the divider must read 0111..1 to fire a step.
    localparam logic [31:0] STEP_MASK  = (DIV_BIT >= 31) ? 32'hFFFF_FFFF
                                       : ((32'd1 << (DIV_BIT + 1)) - 32'd1);
    localparam logic [31:0] STEP_MATCH = (32'd1 << DIV_BIT) - 32'd1;

    logic [31:0] r_div;
    state_t      r_state;
    state_t      w_state_next;
    logic        w_match;
    logic        w_step;

    // Divider counter: wraps naturally, cleared by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div <= 32'd0;
        end else begin
            r_div <= r_div + 32'd1;
        end
    end

    // Step enable from divider match or constant in simulation mode, gated by reset
    always_comb begin
        w_match = 1'b0;
        if (USE_DIV) begin
            w_match = ((r_div & STEP_MASK) == STEP_MATCH);
        end else begin
            w_match = 1'b1;
        end
        w_step = w_match & reset;
    end

    // Pattern state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_OUTER;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-pattern selection; illegal patterns recover to 101 regardless of step
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_OUTER, ST_MID, ST_LEFT, ST_RIGHT: begin
                if (w_step) begin
                    case (wind)
                        2'b01: begin
                            case (r_state)
                                ST_LEFT:  w_state_next = ST_MID;
                                ST_MID:   w_state_next = ST_RIGHT;
                                ST_RIGHT: w_state_next = ST_LEFT;
                                default:  w_state_next = ST_LEFT;
                            endcase
                        end
                        2'b10: begin
                            case (r_state)
                                ST_RIGHT: w_state_next = ST_MID;
                                ST_MID:   w_state_next = ST_LEFT;
                                ST_LEFT:  w_state_next = ST_RIGHT;
                                default:  w_state_next = ST_RIGHT;
                            endcase
                        end
                        default: begin
                            if (r_state == ST_MID) begin
                                w_state_next = ST_OUTER;
                            end else begin
                                w_state_next = ST_MID;
                            end
                        end
                    endcase
                end else begin
                    w_state_next = r_state;
                end
            end
            default: w_state_next = ST_OUTER;
        endcase
    end

    assign leds           = r_state;
    assign divided_clocks = r_div;
    assign step           = w_step;

endmodule

// File: tb/tb_hazard_lights.sv
// Randomized self-checking bench for hazard_lights: one instance steps every clock,
// a second steps on divider bit 2; both are compared against a behavioural model.
module tb_hazard_lights;

    logic        clk;
    logic        reset;
    logic [1:0]  wind;
    logic [2:0]  leds0, leds1;
    logic [31:0] div0, div1;
    logic        step0, step1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [2:0]  m_leds0, m_leds1;
    logic [31:0] m_cnt;
    int          step1_seen;

    hazard_lights #(.DIV_BIT(25), .USE_DIV(1'b0)) u_dut_fast (
        .clk(clk), .reset(reset), .wind(wind),
        .leds(leds0), .divided_clocks(div0), .step(step0)
    );

    hazard_lights #(.DIV_BIT(2), .USE_DIV(1'b1)) u_dut_div (
        .clk(clk), .reset(reset), .wind(wind),
        .leds(leds1), .divided_clocks(div1), .step(step1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Patterns as positions in a ring walked in the wind's direction
    function automatic logic [2:0] ref_next(input logic [2:0] cur, input logic [1:0] w);
        logic [2:0] ring [3];
        int idx;
        if (w == 2'b01) begin
            ring = '{3'b100, 3'b010, 3'b001};
        end else if (w == 2'b10) begin
            ring = '{3'b001, 3'b010, 3'b100};
        end else begin
            return (cur == 3'b010) ? 3'b101 : 3'b010;
        end
        if (cur == 3'b101) return ring[0];
        idx = 0;
        for (int i = 0; i < 3; i++) if (ring[i] == cur) idx = i;
        return ring[(idx + 1) % 3];
    endfunction

    // One clock: check step before the edge, advance model, check state after it
    task automatic tick();
        logic m_step1;
        #4;
        m_step1 = reset && ((m_cnt % 8) == 3);
        check("step_fast", {31'd0, step0}, {31'd0, reset});
        check("step_div", {31'd0, step1}, {31'd0, m_step1});
        if (step1) step1_seen++;
        @(posedge clk);
        if (!reset) begin
            m_cnt   = 32'd0;
            m_leds0 = 3'b101;
            m_leds1 = 3'b101;
        end else begin
            m_cnt   = m_cnt + 32'd1;
            m_leds0 = ref_next(m_leds0, wind);
            if (m_step1) m_leds1 = ref_next(m_leds1, wind);
        end
        #1;
        check("leds_fast", {29'd0, leds0}, {29'd0, m_leds0});
        check("leds_div", {29'd0, leds1}, {29'd0, m_leds1});
        check("div_fast", div0, m_cnt);
        check("div_div", div1, m_cnt);
    endtask

    // Directed sequence on the every-clock instance against literal patterns
    task automatic seq(input logic [1:0] w, input int n, input logic [11:0] exp);
        wind = w;
        for (int i = 0; i < n; i++) begin
            tick();
            check("seq_leds", {29'd0, leds0}, {29'd0, exp[3*(n-1-i) +: 3]});
        end
    endtask

    initial begin
        m_cnt = 32'd0; m_leds0 = 3'b101; m_leds1 = 3'b101; step1_seen = 0;
        reset = 1'b0; wind = 2'b00;
        tick();
        check("rst_leds", {29'd0, leds0}, 32'd5);
        check("rst_div", div0, 32'd0);
        reset = 1'b1;
        seq(2'b00, 1, 12'b010);
        check("first_div", div0, 32'd1);
        seq(2'b00, 1, 12'b101);
        seq(2'b00, 4, 12'b010_101_010_101);
        seq(2'b00, 1, 12'b010);
        seq(2'b01, 4, 12'b001_100_010_001);
        seq(2'b10, 4, 12'b010_100_001_010);
        seq(2'b10, 1, 12'b100);
        seq(2'b11, 2, 12'b010_101);
        seq(2'b01, 1, 12'b100);
        seq(2'b00, 2, 12'b010_101);
        seq(2'b10, 1, 12'b001);

        // Divided instance: exactly one step per 8 clocks
        wind = 2'b00;
        step1_seen = 0;
        for (int i = 0; i < 64; i++) tick();
        check("step_count", step1_seen, 32'd8);

        // Reset in the middle of a left-to-right sweep
        seq(2'b01, 2, 12'b100_010);
        reset = 1'b0;
        tick();
        check("mid_rst_leds", {29'd0, leds0}, 32'd5);
        check("mid_rst_div", div0, 32'd0);
        reset = 1'b1;
        seq(2'b01, 3, 12'b100_010_001);

        // Random wind and sporadic resets against the model
        for (int i = 0; i < 400; i++) begin
            wind  = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 19) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
